// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: little-endian byte-lane writes, optional OKAY wait states
// and a two-cycle ERROR response for illegal size, alignment or range.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int          AW         = IDX_W + 2;
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEM_DEPTH);
    localparam int          WS_LOAD_I  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [1:0]  WS_LOAD    = 2'(WS_LOAD_I);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      cnt_reg, cnt_next;
    logic            dp_valid_reg;
    logic            dp_write_reg;
    logic [2:0]      dp_size_reg;
    logic [AW-1:0]   dp_addr_reg;
    logic [3:0]      fwd_be_reg;
    logic [31:0]     fwd_data_reg;
    logic [31:0]     ram_q;
    logic [31:0]     rd_word;
    logic [3:0]      wr_be;
    logic            ready_out;
    logic            accept;
    logic            addr_err;
    logic            wr_en;
    logic            rd_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]     mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign ready_out = (state_reg != ST_WAIT) && (state_reg != ST_ERR1);
    // Gating with our own ready keeps a misbehaving interconnect from
    // starting a transfer while a data phase is still being extended.
    assign accept    = HSEL && HREADY && HTRANS[1] && ready_out;
    assign addr_err  = (HSIZE > 3'd2)
                    || ({1'b0, HADDR} >= BYTE_LIMIT)
                    || ((HSIZE == 3'd1) && HADDR[0])
                    || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Data-phase registers only advance when the current data phase ends.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_size_reg  <= 3'd0;
            dp_addr_reg  <= '0;
        end else if (ready_out) begin
            dp_valid_reg <= accept && !addr_err;
            if (accept) begin
                dp_write_reg <= HWRITE;
                dp_size_reg  <= HSIZE;
                dp_addr_reg  <= HADDR[AW-1:0];
            end
        end
    end

    always_comb begin
        case (dp_size_reg)
            3'd0:    wr_be = 4'b0001 << dp_addr_reg[1:0];
            3'd1:    wr_be = dp_addr_reg[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    assign wr_en  = (state_reg == ST_IDLE) && dp_valid_reg && dp_write_reg;
    assign rd_en  = accept && !HWRITE && !addr_err;
    assign wr_idx = dp_addr_reg[AW-1:2];
    assign rd_idx = HADDR[AW-1:2];

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[rd_idx];
        end
    end

    // A write committing on the same edge a read of that word is sampled
    // is not yet visible in ram_q, so its lanes are forwarded instead.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_be_reg   <= 4'd0;
            fwd_data_reg <= 32'd0;
        end else if (rd_en) begin
            fwd_be_reg   <= (wr_en && (wr_idx == rd_idx)) ? wr_be : 4'd0;
            fwd_data_reg <= HWDATA;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_word[8*gi +: 8] = fwd_be_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                       : ram_q[8*gi +: 8];
        end
    endgenerate

    assign HRDATA    = ((state_reg == ST_IDLE) && dp_valid_reg && !dp_write_reg) ? rd_word : 32'd0;
    assign HREADYOUT = ready_out;
    assign HRESP     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

endmodule
